// File: rtl/decompress_block_if.sv
// Block decoder port bundle: start pulse, coefficient and quantization
// inputs, reconstructed pixel block and busy/done status.
interface decompress_block_if #(
  parameter int COEFF_WIDTH = 16,
  parameter int QT_WIDTH    = 8
);
  logic                          start_block;
  logic signed [COEFF_WIDTH-1:0] quantized_coeffs [8][8];
  logic        [QT_WIDTH-1:0]    quant_table [8][8];
  logic signed [8:0]             block [8][8];
  logic                          block_busy;
  logic                          block_done;

  modport master (
    output start_block,
    output quantized_coeffs,
    output quant_table,
    input  block,
    input  block_busy,
    input  block_done
  );

  modport slave (
    input  start_block,
    input  quantized_coeffs,
    input  quant_table,
    output block,
    output block_busy,
    output block_done
  );
endinterface

// File: rtl/decompress_block.sv
// 8x8 block decoder: dequantize then separable 2D inverse DCT,
// both passes time-shared on one multiply-accumulate unit.
module decompress_block #(
  parameter int BLOCK_SIZE  = 8,
  parameter int COEFF_WIDTH = 16,
  parameter int QT_WIDTH    = 8,
  parameter int COS_FRAC    = 14,
  parameter int MID_WIDTH   = 44,
  parameter int ACC_WIDTH   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  decompress_block_if.slave bus
);

  localparam int DQ_WIDTH  = COEFF_WIDTH + QT_WIDTH + 1;
  localparam int COS_WIDTH = COS_FRAC + 2;
  localparam int SHIFT     = 2 * COS_FRAC;

  localparam logic signed [ACC_WIDTH-1:0] HALF =
    ACC_WIDTH'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] PMAX = 255;
  localparam logic signed [ACC_WIDTH-1:0] PMIN = -256;

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    DONE
  } state_t;

  state_t state;
  logic [8:0] cnt;
  logic busy_q;
  logic done_q;

  logic signed [ACC_WIDTH-1:0] acc;

  logic signed [COEFF_WIDTH-1:0]
    f_q [BLOCK_SIZE][BLOCK_SIZE];
  logic [QT_WIDTH-1:0]
    t_q [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [MID_WIDTH-1:0]
    g_q [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [8:0]
    pix_q [BLOCK_SIZE][BLOCK_SIZE];

  logic [2:0] hi;
  logic [2:0] mid;
  logic [2:0] lo;

  logic signed [COEFF_WIDTH-1:0] f_sel;
  logic [QT_WIDTH-1:0] t_sel;
  logic signed [DQ_WIDTH-1:0] dq;
  logic signed [COS_WIDTH-1:0] coef;
  logic signed [MID_WIDTH-1:0] opnd;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] rnd;
  logic signed [8:0] pix;

  // Loop indices: PASS1 is (u,y,v), PASS2 is (x,y,u), innermost in lo.
  assign hi  = cnt[8:6];
  assign mid = cnt[5:3];
  assign lo  = cnt[2:0];

  assign bus.block      = pix_q;
  assign bus.block_busy = busy_q;
  assign bus.block_done = done_q;

  // C[n][k] in Q1.14. Odd multiples of k*pi/16 fold onto one
  // quarter-wave table of cos(i*pi/16), i = 0..8.
  function automatic logic signed [COS_WIDTH-1:0] cos_rom(
    input logic [2:0] n,
    input logic [2:0] k
  );
    logic [4:0] m;
    logic [4:0] idx;
    logic neg;
    logic [COS_WIDTH-1:0] mag;
    m   = {1'b0, n, 1'b1} * {2'b00, k};
    idx = m;
    neg = 1'b0;
    if (m > 5'd24) begin
      idx = 5'd0 - m;
    end else if (m > 5'd16) begin
      idx = m - 5'd16;
      neg = 1'b1;
    end else if (m > 5'd8) begin
      idx = 5'd16 - m;
      neg = 1'b1;
    end
    case (idx)
      5'd0:    mag = COS_WIDTH'(8192);
      5'd1:    mag = COS_WIDTH'(8035);
      5'd2:    mag = COS_WIDTH'(7568);
      5'd3:    mag = COS_WIDTH'(6811);
      5'd4:    mag = COS_WIDTH'(5793);
      5'd5:    mag = COS_WIDTH'(4551);
      5'd6:    mag = COS_WIDTH'(3135);
      5'd7:    mag = COS_WIDTH'(1598);
      default: mag = '0;
    endcase
    if (k == 3'd0) begin
      mag = COS_WIDTH'(5793);
      neg = 1'b0;
    end
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // Shared MAC datapath: operand select, accumulate, round and clip.
  always_comb begin
    f_sel = f_q[hi][lo];
    t_sel = t_q[hi][lo];
    dq = DQ_WIDTH'(f_sel) *
         DQ_WIDTH'($signed({1'b0, t_sel}));
    if (state == PASS2) begin
      coef = cos_rom(hi, lo);
      opnd = g_q[lo][mid];
    end else begin
      coef = cos_rom(mid, lo);
      opnd = MID_WIDTH'(dq);
    end
    prod = ACC_WIDTH'(coef) * ACC_WIDTH'(opnd);
    if (lo == 3'd0) begin
      acc_base = '0;
    end else begin
      acc_base = acc;
    end
    acc_next = acc_base + prod;
    rnd = (acc_next + HALF) >>> SHIFT;
    if (rnd > PMAX) begin
      pix = 9'sd255;
    end else if (rnd < PMIN) begin
      pix = -9'sd256;
    end else begin
      pix = rnd[8:0];
    end
  end

  // Control FSM plus all block state: capture, G and pixel stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        for (int j = 0; j < BLOCK_SIZE; j++) begin
          f_q[i][j]   <= '0;
          t_q[i][j]   <= '0;
          g_q[i][j]   <= '0;
          pix_q[i][j] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_block) begin
            f_q    <= bus.quantized_coeffs;
            t_q    <= bus.quant_table;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= PASS1;
          end
        end
        PASS1: begin
          acc <= acc_next;
          cnt <= cnt + 9'd1;
          if (lo == 3'd7) begin
            g_q[hi][mid] <= acc_next[MID_WIDTH-1:0];
          end
          if (cnt == 9'd511) begin
            state <= PASS2;
          end
        end
        PASS2: begin
          acc <= acc_next;
          cnt <= cnt + 9'd1;
          if (lo == 3'd7) begin
            pix_q[hi][mid] <= pix;
          end
          if (cnt == 9'd511) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
